// File: rtl/motion_ctl.sv
// -----------------------------------------------------------------------------
// motion_ctl -- speed/steering controller for a small IR-commanded vehicle.
//
// Commands from the IR decoder go into a one-entry latch. A free-running
// divider produces a tick every CLK_HZ/TICK_HZ clocks. On each tick the
// latched command is applied to a signed speed setpoint (sp) or to the
// steering servo, and the actual speed (act) ramps toward sp by at most STEP.
// The speed magnitude and direction are derived from act, so a reversal always
// passes through zero. Obstacle status is evaluated on every clock. A blocking
// sample clamps forward motion to zero on the next edge, without ramping.
//
// FSM: OFF(0) -> RUN(1) on "on"; RUN -> BLOCKED(2) on a blocking obstacle
// sample; BLOCKED -> RUN on a clear obstacle sample; any state -> OFF on "off".
// If an "off" command, an obstacle sample and a latched command coincide on
// one tick, "off" wins, then the obstacle, then the command.
//
// Optional feature: define MOTION_CTL_WATCHDOG_EN to enable a command-loss
// watchdog. In RUN/BLOCKED it counts ticks with no accepted command. After
// WDOG_TICKS such ticks it zeroes sp, and act then ramps down. Without the
// macro, sp holds indefinitely and no watchdog logic is built.
//
// Ports:
//   clk          in   system clock, all logic on the rising edge
//   rst          in   synchronous active-high reset
//   cmd_valid    in   command strobe from the IR decoder
//   cmd[2:0]     in   000 on, 001 off, 010 fwd, 011 rev,
//                     100 left, 101 right, 110 stop, 111 centre
//   cmd_ready    out  command latch is empty and can take a command
//   obst_valid   in   obstacle status is valid this clock
//   can_move_fwd in   no obstacle ahead (qualified by obst_valid)
//   motor_dc     out  speed magnitude |act|
//   direction    out  1 = forward (act >= 0), 0 = reverse
//   servo_dc     out  steering duty cycle
//   ctl_valid    out  one-clock strobe on the clock after each tick
//   state[1:0]   out  current FSM state
// -----------------------------------------------------------------------------
module motion_ctl #(
    parameter int CLK_HZ     = 25000000,
    parameter int TICK_HZ    = 256,
    parameter int DC_W       = 8,
    parameter int STEP       = 1,
    parameter int SERVO_MIN  = 0,
    parameter int SERVO_MAX  = 2**DC_W - 1,
    parameter int SERVO_CTR  = 2**(DC_W-1),
    parameter int WDOG_TICKS = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    input  logic [2:0]      cmd,
    output logic            cmd_ready,
    input  logic            obst_valid,
    input  logic            can_move_fwd,
    output logic [DC_W-1:0] motor_dc,
    output logic            direction,
    output logic [DC_W-1:0] servo_dc,
    output logic            ctl_valid,
    output logic [1:0]      state
);

    // Elaboration-time sanity checks on the configuration.
    if (CLK_HZ / TICK_HZ < 1) begin : g_bad_div
        $error("CLK_HZ/TICK_HZ must be at least 1");
    end
    if (WDOG_TICKS < 1) begin : g_bad_wdog
        $error("WDOG_TICKS must be at least 1");
    end

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    // sp/act hold +-(2^DC_W-1), so DC_W+1 signed bits. Intermediate sums need
    // one extra bit so that saturation can see the overflow.
    localparam int SP_W = DC_W + 1;
    localparam int EX_W = DC_W + 2;

    localparam logic signed [EX_W-1:0] LIM_X  = EX_W'(2**DC_W - 1);
    localparam logic signed [EX_W-1:0] STEP_X = EX_W'(STEP);

    localparam logic [DC_W:0]   SV_MIN  = (DC_W+1)'(SERVO_MIN);
    localparam logic [DC_W:0]   SV_MAX  = (DC_W+1)'(SERVO_MAX);
    localparam logic [DC_W:0]   SV_STEP = (DC_W+1)'(STEP);
    localparam logic [DC_W-1:0] SV_CTR  = DC_W'(SERVO_CTR);

    localparam logic [2:0] CMD_ON    = 3'b000;
    localparam logic [2:0] CMD_OFF   = 3'b001;
    localparam logic [2:0] CMD_FWD   = 3'b010;
    localparam logic [2:0] CMD_REV   = 3'b011;
    localparam logic [2:0] CMD_LEFT  = 3'b100;
    localparam logic [2:0] CMD_RIGHT = 3'b101;
    localparam logic [2:0] CMD_STOP  = 3'b110;
    localparam logic [2:0] CMD_CTR   = 3'b111;

    typedef enum logic [1:0] {
        S_OFF     = 2'd0,
        S_RUN     = 2'd1,
        S_BLOCKED = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Arithmetic helpers
    // -------------------------------------------------------------------------
    function automatic logic signed [EX_W-1:0] ext(input logic signed [SP_W-1:0] v);
        return $signed({v[SP_W-1], v});
    endfunction

    function automatic logic signed [SP_W-1:0] sat_sp(input logic signed [EX_W-1:0] v);
        if (v > LIM_X)
            return SP_W'(LIM_X);
        else if (v < -LIM_X)
            return SP_W'(-LIM_X);
        else
            return SP_W'(v);
    endfunction

    // Move a toward s by at most STEP; land exactly on s rather than overshoot.
    function automatic logic signed [SP_W-1:0] ramp(input logic signed [SP_W-1:0] a,
                                                    input logic signed [SP_W-1:0] s);
        logic signed [EX_W-1:0] ax;
        logic signed [EX_W-1:0] sx;
        ax = ext(a);
        sx = ext(s);
        if (ax < sx)
            return (sx - ax > STEP_X) ? SP_W'(ax + STEP_X) : s;
        else if (ax > sx)
            return (ax - sx > STEP_X) ? SP_W'(ax - STEP_X) : s;
        else
            return a;
    endfunction

    // min(v, 0)
    function automatic logic signed [SP_W-1:0] clamp_nonpos(input logic signed [SP_W-1:0] v);
        return v[SP_W-1] ? v : '0;
    endfunction

    function automatic logic [DC_W-1:0] mag(input logic signed [SP_W-1:0] v);
        return v[SP_W-1] ? DC_W'(-v) : DC_W'(v);
    endfunction

    function automatic logic [DC_W-1:0] servo_left(input logic [DC_W-1:0] s);
        logic [DC_W:0] sx;
        sx = {1'b0, s};
        return (sx < SV_MIN + SV_STEP) ? DC_W'(SV_MIN) : DC_W'(sx - SV_STEP);
    endfunction

    function automatic logic [DC_W-1:0] servo_right(input logic [DC_W-1:0] s);
        logic [DC_W:0] sx;
        sx = {1'b0, s};
        return (sx + SV_STEP > SV_MAX) ? DC_W'(SV_MAX) : DC_W'(sx + SV_STEP);
    endfunction

    // -------------------------------------------------------------------------
    // Tick divider
    // -------------------------------------------------------------------------
    logic [DIV_W-1:0] div_q;
    logic             tick;

    assign tick = (div_q == DIV_W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst)
            div_q <= '0;
        else
            div_q <= tick ? '0 : div_q + 1'b1;
    end

    // -------------------------------------------------------------------------
    // One-entry command latch
    // -------------------------------------------------------------------------
    logic       latch_full;
    logic       latch_nx;
    logic       accept;
    logic       cmd_now;
    logic [2:0] cmd_q;

    assign accept   = cmd_valid && cmd_ready;
    // The latched command is consumed by the tick. A command accepted on the
    // tick edge itself waits for the following tick.
    assign cmd_now  = tick && latch_full;
    assign latch_nx = (latch_full && !tick) || accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            latch_full <= 1'b0;
            cmd_ready  <= 1'b0;
        end else begin
            latch_full <= latch_nx;
            cmd_ready  <= !latch_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            cmd_q <= cmd;
    end

    // -------------------------------------------------------------------------
    // FSM and datapath
    // -------------------------------------------------------------------------
    state_t                 state_q;
    state_t                 state_nx;
    logic signed [SP_W-1:0] sp_q;
    logic signed [SP_W-1:0] sp_nx;
    logic signed [SP_W-1:0] act_q;
    logic signed [SP_W-1:0] act_nx;
    logic [DC_W-1:0]        servo_q;
    logic [DC_W-1:0]        servo_nx;
    logic                   blocking;
    logic                   clearing;

    assign blocking = obst_valid && !can_move_fwd;
    assign clearing = obst_valid && can_move_fwd;

`ifdef MOTION_CTL_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_TICKS + 1);

    logic [WD_W-1:0] wdog_q;
    logic            wdog_hit;

    // Fires on the tick that would complete WDOG_TICKS command-free ticks.
    assign wdog_hit = tick && (state_q != S_OFF) && !latch_full && !accept
                      && (wdog_q == WD_W'(WDOG_TICKS - 1));

    always_ff @(posedge clk) begin
        if (rst || state_q == S_OFF || accept)
            wdog_q <= '0;
        else if (tick) begin
            if (latch_full)
                wdog_q <= '0;
            else if (wdog_q != WD_W'(WDOG_TICKS))
                wdog_q <= wdog_q + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_OFF;
        else
            state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        sp_nx    = sp_q;
        act_nx   = act_q;
        servo_nx = servo_q;

        if (cmd_now && cmd_q == CMD_OFF) begin
            state_nx = S_OFF;
            sp_nx    = '0;
            act_nx   = '0;
            servo_nx = SV_CTR;
        end else begin
            case (state_q)
                S_OFF: begin
                    sp_nx    = '0;
                    act_nx   = '0;
                    servo_nx = SV_CTR;
                    if (cmd_now && cmd_q == CMD_ON)
                        state_nx = S_RUN;
                end
                S_RUN: begin
                    if (blocking)
                        state_nx = S_BLOCKED;
                end
                S_BLOCKED: begin
                    if (clearing)
                        state_nx = S_RUN;
                end
                default: state_nx = S_OFF;
            endcase

            // Blocking takes effect immediately, no ramp.
            if (state_nx == S_BLOCKED) begin
                sp_nx  = clamp_nonpos(sp_nx);
                act_nx = clamp_nonpos(act_nx);
            end

            if (tick && state_q != S_OFF) begin
                if (cmd_now) begin
                    case (cmd_q)
                        CMD_FWD:   sp_nx    = sat_sp(ext(sp_nx) + STEP_X);
                        CMD_REV:   sp_nx    = sat_sp(ext(sp_nx) - STEP_X);
                        CMD_STOP:  sp_nx    = '0;
                        CMD_LEFT:  servo_nx = servo_left(servo_nx);
                        CMD_RIGHT: servo_nx = servo_right(servo_nx);
                        CMD_CTR:   servo_nx = SV_CTR;
                        default:   ;  // "on" while already running is a no-op
                    endcase
                end
`ifdef MOTION_CTL_WATCHDOG_EN
                if (wdog_hit)
                    sp_nx = '0;
`endif
                if (state_nx == S_BLOCKED)
                    sp_nx = clamp_nonpos(sp_nx);
                act_nx = ramp(act_nx, sp_nx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q    <= '0;
            act_q   <= '0;
            servo_q <= SV_CTR;
        end else begin
            sp_q    <= sp_nx;
            act_q   <= act_nx;
            servo_q <= servo_nx;
        end
    end

    // -------------------------------------------------------------------------
    // Registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            motor_dc  <= '0;
            direction <= 1'b1;
            ctl_valid <= 1'b0;
        end else begin
            motor_dc  <= mag(act_nx);
            direction <= !act_nx[SP_W-1];
            ctl_valid <= tick;
        end
    end

    assign servo_dc = servo_q;
    assign state    = state_q;

endmodule

// File: tb/tb_motion_ctl.sv
// -----------------------------------------------------------------------------
// tb_motion_ctl -- scoreboard bench for motion_ctl (CLK_HZ=16, TICK_HZ=1,
// DC_W=8, STEP=4, so one tick every 16 clocks).
//
// Each tick-level step drives an optional command and pushes the output
// expected after the next tick onto a queue. The entry is then popped and
// compared when ctl_valid pulses. Expected values are hand-derived constants.
// Build with MOTION_CTL_WATCHDOG_EN to exercise the watchdog with WDOG_TICKS=4.
// -----------------------------------------------------------------------------
module tb_motion_ctl;

    localparam int DC_W = 8;
`ifdef MOTION_CTL_WATCHDOG_EN
    localparam int WD = 4;
`else
    localparam int WD = 64;
`endif

    localparam logic [2:0] C_ON    = 3'b000;
    localparam logic [2:0] C_OFF   = 3'b001;
    localparam logic [2:0] C_FWD   = 3'b010;
    localparam logic [2:0] C_REV   = 3'b011;
    localparam logic [2:0] C_LEFT  = 3'b100;
    localparam logic [2:0] C_RIGHT = 3'b101;
    localparam logic [2:0] C_STOP  = 3'b110;
    localparam logic [2:0] C_CTR   = 3'b111;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cmd_valid = 1'b0;
    logic [2:0]      cmd = 3'b000;
    logic            cmd_ready;
    logic            obst_valid = 1'b0;
    logic            can_move_fwd = 1'b1;
    logic [DC_W-1:0] motor_dc;
    logic            direction;
    logic [DC_W-1:0] servo_dc;
    logic            ctl_valid;
    logic [1:0]      state;

    motion_ctl #(
        .CLK_HZ    (16),
        .TICK_HZ   (1),
        .DC_W      (DC_W),
        .STEP      (4),
        .WDOG_TICKS(WD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd         (cmd),
        .cmd_ready   (cmd_ready),
        .obst_valid  (obst_valid),
        .can_move_fwd(can_move_fwd),
        .motor_dc    (motor_dc),
        .direction   (direction),
        .servo_dc    (servo_dc),
        .ctl_valid   (ctl_valid),
        .state       (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mdc;
        int dir;
        int servo;
        int st;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic wait_vld(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ctl_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok)
            check_eq("ctl_valid_timeout", 0, 1);
    endtask

    task automatic push_exp(input int mdc, input int dir, input int servo, input int st);
        exp_t e;
        e.mdc   = mdc;
        e.dir   = dir;
        e.servo = servo;
        e.st    = st;
        sb_q.push_back(e);
    endtask

    task automatic expect_tick(input string tag);
        exp_t e;
        bit   ok;
        wait_vld(ok);
        e = sb_q.pop_front();
        check_eq({tag, ".motor_dc"},  int'(motor_dc),  e.mdc);
        check_eq({tag, ".direction"}, int'(direction), e.dir);
        check_eq({tag, ".servo_dc"},  int'(servo_dc),  e.servo);
        check_eq({tag, ".state"},     int'(state),     e.st);
    endtask

    // Called at the negedge just after a ctl_valid pulse.
    task automatic send_cmd(input string tag, input logic [2:0] c);
        check_eq({tag, ".cmd_ready"}, int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd       = c;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic do_tick(input string tag, input bit has, input logic [2:0] c,
                           input int mdc, input int dir, input int servo, input int st);
        if (has)
            send_cmd(tag, c);
        push_exp(mdc, dir, servo, st);
        expect_tick(tag);
    endtask

    initial begin
        #300000;
        $display("FAIL sim_timeout: got no finish, expected finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        bit ok;
        int sv;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst.motor_dc",  int'(motor_dc),  0);
        check_eq("rst.direction", int'(direction), 1);
        check_eq("rst.servo_dc",  int'(servo_dc),  128);
        check_eq("rst.ctl_valid", int'(ctl_valid), 0);
        check_eq("rst.cmd_ready", int'(cmd_ready), 0);
        check_eq("rst.state",     int'(state),     0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_release.cmd_ready", int'(cmd_ready), 1);
        wait_vld(ok);
        check_eq("first_tick.state", int'(state), 0);

        // On, then ramp forward
        do_tick("on",   1, C_ON,  0,  1, 128, 1);
        do_tick("fwd1", 1, C_FWD, 4,  1, 128, 1);
        do_tick("fwd2", 1, C_FWD, 8,  1, 128, 1);
        do_tick("fwd3", 1, C_FWD, 12, 1, 128, 1);

        // Back to sp=act=+8, then reverse through zero
        do_tick("rev0", 1, C_REV, 8, 1, 128, 1);
        do_tick("rev1", 1, C_REV, 4, 1, 128, 1);
        do_tick("rev2", 1, C_REV, 0, 1, 128, 1);
        do_tick("rev3", 1, C_REV, 4, 0, 128, 1);
        do_tick("rev4", 1, C_REV, 8, 0, 128, 1);

        // Stop ramps to zero, then build act=+12
        do_tick("stop",  1, C_STOP, 4,  0, 128, 1);
        do_tick("idle1", 0, C_ON,   0,  1, 128, 1);
        do_tick("fwd4",  1, C_FWD,  4,  1, 128, 1);
        do_tick("fwd5",  1, C_FWD,  8,  1, 128, 1);
        do_tick("fwd6",  1, C_FWD,  12, 1, 128, 1);

        // Obstacle between ticks: motor stops on the next clock
        obst_valid   = 1'b1;
        can_move_fwd = 1'b0;
        @(negedge clk);
        check_eq("obst.motor_dc", int'(motor_dc), 0);
        check_eq("obst.state",    int'(state),    2);
        obst_valid   = 1'b0;
        can_move_fwd = 1'b1;
        do_tick("blk_fwd", 1, C_FWD, 0, 1, 128, 2);
        obst_valid = 1'b1;
        @(negedge clk);
        check_eq("unblock.state", int'(state), 1);
        obst_valid = 1'b0;

        // Second command while the latch is full is refused
        send_cmd("full", C_FWD);
        check_eq("full.cmd_ready_after_accept", int'(cmd_ready), 0);
        cmd_valid = 1'b1;
        cmd       = C_REV;
        @(negedge clk);
        check_eq("full.cmd_ready_held", int'(cmd_ready), 0);
        cmd_valid = 1'b0;
        push_exp(4, 1, 128, 1);
        expect_tick("full_tick");
        do_tick("idle2", 0, C_ON, 4, 1, 128, 1);

        // "off" and a blocking obstacle on the same tick: off wins
        send_cmd("off_obst", C_OFF);
        repeat (14) @(negedge clk);
        obst_valid   = 1'b1;
        can_move_fwd = 1'b0;
        push_exp(0, 1, 128, 0);
        expect_tick("off_obst");
        obst_valid   = 1'b0;
        can_move_fwd = 1'b1;

        // OFF discards commands other than "on"
        do_tick("off_fwd", 1, C_FWD, 0, 1, 128, 0);
        do_tick("on2",     1, C_ON,  0, 1, 128, 1);

        // Steering saturation and centre
        for (int i = 1; i <= 33; i++) begin
            sv = (128 + 4 * i > 255) ? 255 : 128 + 4 * i;
            do_tick($sformatf("right%0d", i), 1, C_RIGHT, 0, 1, sv, 1);
        end
        do_tick("centre", 1, C_CTR,  0, 1, 128, 1);
        do_tick("left",   1, C_LEFT, 0, 1, 124, 1);

        // sp=+8 followed by silence
        do_tick("hfwd1", 1, C_FWD, 4, 1, 124, 1);
        do_tick("hfwd2", 1, C_FWD, 8, 1, 124, 1);
`ifdef MOTION_CTL_WATCHDOG_EN
        do_tick("wd1", 0, C_ON, 8, 1, 124, 1);
        do_tick("wd2", 0, C_ON, 8, 1, 124, 1);
        do_tick("wd3", 0, C_ON, 8, 1, 124, 1);
        do_tick("wd4", 0, C_ON, 4, 1, 124, 1);
        do_tick("wd5", 0, C_ON, 0, 1, 124, 1);
`else
        for (int i = 1; i <= 5; i++)
            do_tick($sformatf("hold%0d", i), 0, C_ON, 8, 1, 124, 1);
`endif

        // Reset with a pending command discards it
        send_cmd("rst_mid", C_ON);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_mid.motor_dc",  int'(motor_dc),  0);
        check_eq("rst_mid.servo_dc",  int'(servo_dc),  128);
        check_eq("rst_mid.cmd_ready", int'(cmd_ready), 0);
        check_eq("rst_mid.state",     int'(state),     0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_release.cmd_ready", int'(cmd_ready), 1);
        push_exp(0, 1, 128, 0);
        expect_tick("after_rst");

        check_eq("scoreboard_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
